// File: rtl/gray_step_monitor.sv
// Gray step monitor: decodes a two-digit 4-bit reflected gray word, then
// classifies each sample against the previous one as a legal step, a hold
// or an error in the requested direction. Lock is dropped after LOCK_LOSS
// consecutive errors.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid          gray_in/dir carry a sample this cycle
//   gray_in[7:0]      two gray digits, [7:4] high and [3:0] low
//   dir               expected direction: 1 = up, 0 = down
//   bin_out[7:0]      decoded value of the last accepted sample
//   out_valid         one-cycle pulse, bin_out and flags are valid
//   step_ok/hold/err  step classification (all 0 on a seed sample)
//   wrap              step_ok that crossed 0xFF <-> 0x00
//   locked            monitor is in LOCKED after this edge
//   err_cnt[7:0]      saturating total of step errors since reset
module gray_step_monitor #(
  parameter int unsigned LOCK_LOSS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] gray_in,
  input  logic       dir,
  output logic [7:0] bin_out,
  output logic       out_valid,
  output logic       step_ok,
  output logic       step_hold,
  output logic       step_err,
  output logic       wrap,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [W-1:0]    err_cnt_q, err_cnt_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            out_valid_q, out_valid_d;
  logic            step_ok_q, step_ok_d;
  logic            step_hold_q, step_hold_d;
  logic            step_err_q, step_err_d;
  logic            wrap_q, wrap_d;
  logic            locked_q, locked_d;

  logic [W-1:0]    sample_bin;
  logic [W-1:0]    delta;
  logic [CW-1:0]   consec_inc;

  // Reflected gray to binary for one 4-bit digit.
  function automatic logic [3:0] gray2bin4(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  // Digits decode independently; bin_q doubles as the previous sample.
  assign sample_bin = {gray2bin4(gray_in[7:4]), gray2bin4(gray_in[3:0])};
  assign delta      = sample_bin - bin_q;
  assign consec_inc = consec_q + CW'(1);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    err_cnt_d   = err_cnt_q;
    consec_d    = consec_q;
    out_valid_d = 1'b0;
    step_ok_d   = 1'b0;
    step_hold_d = 1'b0;
    step_err_d  = 1'b0;
    wrap_d      = 1'b0;

    if (in_valid) begin
      out_valid_d = 1'b1;
      bin_d       = sample_bin;
      case (state_q)
        UNLOCKED: begin
          // Seed sample: no classification, just arm the monitor.
          state_d  = LOCKED;
          consec_d = '0;
        end
        LOCKED: begin
          if (delta == W'(0)) begin
            step_hold_d = 1'b1;
            consec_d    = '0;
          end else if ((dir && delta == W'(1)) || (!dir && delta == W'(8'hFF))) begin
            step_ok_d = 1'b1;
            // A legal up step from 0xFF can only land on 0x00, and vice versa.
            wrap_d    = dir ? (bin_q == W'(8'hFF)) : (bin_q == W'(0));
            consec_d  = '0;
          end else begin
            step_err_d = 1'b1;
            if (err_cnt_q != W'(8'hFF)) begin
              err_cnt_d = err_cnt_q + W'(1);
            end
            if (consec_inc == CW'(LOCK_LOSS)) begin
              state_d  = UNLOCKED;
              consec_d = '0;
            end else begin
              consec_d = consec_inc;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      bin_q       <= '0;
      err_cnt_q   <= '0;
      consec_q    <= '0;
      out_valid_q <= 1'b0;
      step_ok_q   <= 1'b0;
      step_hold_q <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      err_cnt_q   <= err_cnt_d;
      consec_q    <= consec_d;
      out_valid_q <= out_valid_d;
      step_ok_q   <= step_ok_d;
      step_hold_q <= step_hold_d;
      step_err_q  <= step_err_d;
      wrap_q      <= wrap_d;
      locked_q    <= locked_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;
  assign step_ok   = step_ok_q;
  assign step_hold = step_hold_q;
  assign step_err  = step_err_q;
  assign wrap      = wrap_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: directed scenarios followed by random samples,
// every cycle compared against an arithmetic reference model.
module tb_gray_step_monitor;

  localparam int unsigned LL = 3;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] gray_in;
  logic       dir;
  logic [7:0] bin_out;
  logic       out_valid;
  logic       step_ok;
  logic       step_hold;
  logic       step_err;
  logic       wrap;
  logic       locked;
  logic [7:0] err_cnt;

  gray_step_monitor #(.LOCK_LOSS(LL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .dir       (dir),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .step_ok   (step_ok),
    .step_hold (step_hold),
    .step_err  (step_err),
    .wrap      (wrap),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Reference model state.
  int m_locked = 0;
  int m_prev   = 0;
  int m_err    = 0;
  int m_consec = 0;
  // Expected outputs.
  int e_bin = 0, e_vld = 0, e_ok = 0, e_hold = 0, e_err = 0, e_wrap = 0;

  // Binary to gray, one digit at a time.
  function automatic logic [7:0] enc(input int b);
    int hi, lo;
    hi = (b >> 4) & 15;
    lo = b & 15;
    return 8'(((hi ^ (hi >> 1)) << 4) | (lo ^ (lo >> 1)));
  endfunction

  // Gray to binary for one digit: prefix xor of all higher bits.
  function automatic int dec_digit(input int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input int exp);
    total_cnt++;
    assert (obs === 8'(exp)) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, 8'(exp));
    end
  endtask

  task automatic model(input logic r, input logic v, input logic [7:0] g, input logic d);
    int b, delta;
    e_vld = 0; e_ok = 0; e_hold = 0; e_err = 0; e_wrap = 0;
    if (r) begin
      m_locked = 0; m_prev = 0; m_err = 0; m_consec = 0;
    end else if (v) begin
      b = (dec_digit(int'(g) >> 4) << 4) | dec_digit(int'(g) & 15);
      e_vld = 1;
      if (m_locked == 0) begin
        m_locked = 1;
        m_consec = 0;
      end else begin
        delta = (b - m_prev + 256) % 256;
        if (delta == 0) begin
          e_hold = 1; m_consec = 0;
        end else if ((d && delta == 1) || (!d && delta == 255)) begin
          e_ok = 1; m_consec = 0;
          e_wrap = int'((d && m_prev == 255 && b == 0) || (!d && m_prev == 0 && b == 255));
        end else begin
          e_err = 1;
          if (m_err < 255) m_err++;
          m_consec++;
          if (m_consec == LL) begin
            m_locked = 0; m_consec = 0;
          end
        end
      end
      m_prev = b;
    end
    e_bin = m_prev;
  endtask

  // Drive one cycle, advance the model, compare every output.
  task automatic cyc(input logic r, input logic v, input logic [7:0] g, input logic d);
    rst = r; in_valid = v; gray_in = g; dir = d;
    @(posedge clk);
    #1;
    model(r, v, g, d);
    chk("bin_out",   bin_out,          e_bin);
    chk("out_valid", 8'(out_valid),    e_vld);
    chk("step_ok",   8'(step_ok),      e_ok);
    chk("step_hold", 8'(step_hold),    e_hold);
    chk("step_err",  8'(step_err),     e_err);
    chk("wrap",      8'(wrap),         e_wrap);
    chk("locked",    8'(locked),       m_locked);
    chk("err_cnt",   err_cnt,          m_err);
  endtask

  task automatic smp(input int b, input logic d);
    cyc(1'b0, 1'b1, enc(b), d);
  endtask

  int cur;
  int nxt;
  logic rdir;

  initial begin
    rst = 1'b1; in_valid = 1'b0; gray_in = '0; dir = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("reset_locked", 8'(locked), 0);

    // Seed then single up step.
    smp(8'h00, 1'b1);
    chk("seed_locked", 8'(locked), 1);
    chk("seed_flags", {4'h0, step_ok, step_hold, step_err, wrap}, 0);
    smp(8'h01, 1'b1);
    chk("step1_ok", 8'(step_ok), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("idle_hold_bin", bin_out, 8'h01);

    // Up wrap and down wrap; 0x88 decodes to 0xFF.
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h88, 1'b1);
    chk("dec_88", bin_out, 8'hFF);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    chk("upwrap", {6'h0, step_ok, wrap}, 3);
    cyc(1'b0, 1'b1, 8'h88, 1'b0);
    chk("dnwrap", {6'h0, step_ok, wrap}, 3);

    // Hold then error (gray 0x02 decodes to 0x03).
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    chk("hold", 8'(step_hold), 1);
    cyc(1'b0, 1'b1, 8'h02, 1'b1);
    chk("err_bin", bin_out, 8'h03);
    chk("err_cnt1", err_cnt, 1);

    // Lock loss on the third consecutive error, then re-seed.
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    smp(8'h00, 1'b1);
    smp(8'h05, 1'b1);
    smp(8'h0A, 1'b1);
    chk("pre_loss_locked", 8'(locked), 1);
    smp(8'h20, 1'b1);
    chk("loss_locked", 8'(locked), 0);
    chk("loss_err", 8'(step_err), 1);
    smp(8'h21, 1'b1);
    chk("reseed", {3'h0, locked, step_ok, step_hold, step_err, wrap}, 8'h10);

    // Error saturation, alternating 0x00/0x80 never steps legally.
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 460; i++) smp((i % 2 == 0) ? 8'h00 : 8'h80, 1'b1);
    chk("err_sat", err_cnt, 8'hFF);
    cyc(1'b1, 1'b1, enc(8'h81), 1'b1);
    chk("rst_over_valid", {out_valid, locked, 6'h0}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    smp(8'h10, 1'b1);
    chk("post_rst_seed", bin_out, 8'h10);
    chk("post_rst_flags", {4'h0, step_ok, step_hold, step_err, wrap}, 0);

    // Random walk biased toward legal steps and holds.
    cur = 8'h10;
    rdir = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) rdir = ~rdir;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: nxt = rdir ? (cur + 1) % 256 : (cur + 255) % 256;
        5:             nxt = cur;
        6:             nxt = rdir ? 255 : 0;
        default:       nxt = int'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 199) == 0) begin
        cyc(1'b1, 1'($urandom_range(0, 1)), enc(nxt), rdir);
      end else if ($urandom_range(0, 6) == 0) begin
        cyc(1'b0, 1'b0, enc(nxt), rdir);
      end else begin
        cyc(1'b0, 1'b1, enc(nxt), rdir);
        cur = nxt;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gray_step_monitor.md
GRAY_STEP_MONITOR -- requirements
Module: gray_step_monitor

Interface
REQ-001 Parameter: LOCK_LOSS, default 3, number of consecutive step errors (legal range 1..7) that drops lock.
REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  gray_in/dir carry a sample this cycle.
- gray_in  input  8  two-digit gray word: [7:4] high digit, [3:0] low digit, each an independent 4-bit reflected gray code.
- dir  input  1  expected count direction for this sample: 1 = up, 0 = down.
- bin_out  output  8  decoded binary value of last accepted sample.
- out_valid  output  1  one-cycle pulse; bin_out and step flags valid.
- step_ok  output  1  sample is exactly one step from the previous one in the dir direction.
- step_hold  output  1  sample equals previous one (counter stalled).
- step_err  output  1  any other delta.
- wrap  output  1  step_ok step crossed 0xFF->0x00 (up) or 0x00->0xFF (down).
- locked  output  1  FSM in LOCKED.
- err_cnt  output  8  total step errors since reset, saturating.

Function
REQ-003 Decode SHALL be per digit: bin[7:4] = gray2bin(gray_in[7:4]) and bin[3:0] = gray2bin(gray_in[3:0]), where b3=g3 and bi=g(i)^b(i+1); 0x88 decodes to 0xFF.
REQ-004 Latency SHALL be 1 cycle: a sample with in_valid=1 at edge N produces out_valid=1 and updated outputs after edge N; out_valid=0 on cycles after edges with in_valid=0.
REQ-005 The block SHALL register the decoded value and hold it in prev until the next accepted sample; bin_out SHALL hold its value between samples.
REQ-006 The FSM SHALL have two states, UNLOCKED and LOCKED; the reset state is UNLOCKED.
REQ-007 In UNLOCKED, a valid sample SHALL seed prev, assert out_valid with step_ok/step_hold/step_err/wrap all 0, and move the FSM to LOCKED.
REQ-008 In LOCKED, the delta SHALL be computed modulo 256 as d = bin - prev.
- d==0: step_hold.
- dir=1 and d==1: step_ok.
- dir=0 and d==0xFF: step_ok.
- otherwise: step_err.
REQ-009 Exactly one of step_ok/step_hold/step_err SHALL be 1 with each LOCKED out_valid pulse; all SHALL be 0 when out_valid=0.
REQ-010 wrap SHALL be 1 only together with step_ok, when prev=0xFF,bin=0x00 (dir=1) or prev=0x00,bin=0xFF (dir=0).
REQ-011 dir SHALL be sampled per sample; a dir change between samples is legal and checked against the new dir.
REQ-012 Each step_err SHALL increment err_cnt, which saturates at 0xFF.
REQ-013 A consecutive-error counter (3 bits) SHALL increment on step_err and clear on step_ok or step_hold; when it reaches LOCK_LOSS, the FSM SHALL go to UNLOCKED and the counter SHALL clear.
REQ-014 In all cases the errored sample SHALL still update prev and bin_out.
REQ-015 locked SHALL reflect the state after the edge; on the lock-loss sample, locked=0 in the same cycle as that sample's out_valid.

Reset
REQ-016 When rst=1 at an edge, the block SHALL set bin_out=0x00, out_valid=0, all step flags=0, wrap=0, locked=0, err_cnt=0x00, prev=0x00, consecutive-error count=0, and state=UNLOCKED.
REQ-017 rst SHALL override in_valid in the same cycle; a reset mid-stream discards prev, so the next sample re-seeds.

Verification
REQ-018 Seed/step: samples 0x00 then 0x01 with dir=1 -> bin_out 0x00 (flags 0, locked=1), then 0x01 with step_ok=1.
REQ-019 Up wrap: prev sample 0x88 then 0x00 with dir=1 -> bin_out 0xFF then 0x00, step_ok=1, wrap=1; down wrap 0x00 -> 0x88 with dir=0 -> bin_out 0xFF, step_ok=1, wrap=1.
REQ-020 Hold and error: 0x01, 0x01, 0x02 with dir=1 -> step_hold on the second sample, step_err on the third (bin 0x03, delta 2), err_cnt=1.
REQ-021 Lock loss: after lock, three error samples with LOCK_LOSS=3 -> locked=0 with the third out_valid; the next sample re-seeds with flags 0 and locked=1.
REQ-022 Reset/saturation: drive 300 error steps -> err_cnt=0xFF; rst=1 with in_valid=1 -> all outputs zero and no out_valid; sample 0x10 afterwards -> bin_out 0x10 as seed.
